// File: rtl/uart_rx_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl_pkg
// Shared definitions for the UART frame controller: FSM state encoding,
// error code values, the default sync byte and the checksum helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // 8-bit additive checksum step, wraps mod 256
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return 8'(a + b);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Bundles the receiver byte strobe, the host frame handshake, the buffer read
// port and the status pulses of the frame controller.
//   master : host / receiver side (drives strobes, ack, read address)
//   slave  : the frame controller
// Parameter AW: buffer read address width.
// -----------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if #(
    parameter int AW = 4
);
    logic          i_rx_dv;
    logic [7:0]    i_rx_byte;
    logic          o_frame_valid;
    logic [7:0]    o_frame_len;
    logic          i_frame_ack;
    logic [AW-1:0] i_rd_addr;
    logic [7:0]    o_rd_data;
    logic          o_err;
    logic [1:0]    o_err_code;
    logic          o_overrun;

    modport master (
        output i_rx_dv, i_rx_byte, i_frame_ack, i_rd_addr,
        input  o_frame_valid, o_frame_len, o_rd_data, o_err, o_err_code, o_overrun
    );

    modport slave (
        input  i_rx_dv, i_rx_byte, i_frame_ack, i_rd_addr,
        output o_frame_valid, o_frame_len, o_rd_data, o_err, o_err_code, o_overrun
    );
endinterface

// File: rtl/uart_rx_frame_ctrl_buf.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl_buf
// DEPTH x 8 payload register file: one synchronous write port, one registered
// read port. Storage is not reset; only the read register clears on rst.
// Ports: clk, rst, we/waddr/wdata (write), raddr/rdata (read, 1-cycle latency).
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem_r [DEPTH];

    // Payload storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; addresses beyond the array read as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'h00;
        end else if (32'(raddr) < 32'(DEPTH)) begin
            rdata <= mem_r[raddr];
        end else begin
            rdata <= 8'h00;
        end
    end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Frame controller behind the UART receiver: hunts for SYNC_BYTE, takes a
// length byte, collects the payload into a local buffer, verifies an 8-bit
// additive checksum (seeded with the length) and enforces an inter-byte
// timeout. A verified frame is held for the host (valid/ack + read port);
// bad frames pulse o_err with a held error code; bytes arriving while a frame
// is held are dropped and pulse o_overrun.
// Ports: clk, rst (sync, active high), bus (uart_rx_frame_ctrl_if.slave).
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 3480,
    parameter int         AW           = $clog2(MAX_LEN)
) (
    input logic                 clk,
    input logic                 rst,
    uart_rx_frame_ctrl_if.slave bus
);
    localparam int IW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT_CLKS);

    state_t        state_r, state_s;
    logic [TW-1:0] timer_r, timer_s, timer_inc_s;
    logic [IW-1:0] idx_r, idx_s;
    logic [7:0]    len_r, len_s;
    logic [7:0]    sum_r, sum_s;
    logic          frame_valid_r, frame_valid_s;
    logic [7:0]    frame_len_r, frame_len_s;
    logic          err_r, err_s;
    logic [1:0]    err_code_r, err_code_s;
    logic          overrun_r, overrun_s;
    logic          buf_we_s;
    logic [7:0]    rd_data_s;

    logic in_frame_s, timeout_s, len_bad_s, last_payload_s, is_sync_s;

    assign in_frame_s     = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CSUM);
    // Expiry is judged on the edge that would take the timer to TIMEOUT_CLKS;
    // a strobe on that same edge takes priority.
    assign timeout_s      = in_frame_s && !bus.i_rx_dv && (timer_r == TMR_LAST);
    assign len_bad_s      = (bus.i_rx_byte == 8'h00) || (32'(bus.i_rx_byte) > 32'(MAX_LEN));
    assign last_payload_s = (32'(idx_r) + 32'd1) == 32'(len_r);
    assign is_sync_s      = bus.i_rx_dv && (bus.i_rx_byte == SYNC_BYTE);
    assign timer_inc_s    = (timer_r == TMR_MAX) ? timer_r : timer_r + TW'(1'b1);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (is_sync_s) state_s = ST_LEN;
                else           state_s = ST_IDLE;
            end
            ST_LEN: begin
                if (bus.i_rx_dv)    state_s = len_bad_s ? ST_IDLE : ST_PAYLOAD;
                else if (timeout_s) state_s = ST_IDLE;
                else                state_s = ST_LEN;
            end
            ST_PAYLOAD: begin
                if (bus.i_rx_dv)    state_s = last_payload_s ? ST_CSUM : ST_PAYLOAD;
                else if (timeout_s) state_s = ST_IDLE;
                else                state_s = ST_PAYLOAD;
            end
            ST_CSUM: begin
                if (bus.i_rx_dv)    state_s = (bus.i_rx_byte == sum_r) ? ST_DONE : ST_IDLE;
                else if (timeout_s) state_s = ST_IDLE;
                else                state_s = ST_CSUM;
            end
            ST_DONE: begin
                // The byte arriving with ack is dropped, never examined for sync
                if (bus.i_frame_ack) state_s = ST_IDLE;
                else                 state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered status outputs and buffer write
    always_comb begin
        err_s         = 1'b0;
        err_code_s    = err_code_r;
        overrun_s     = 1'b0;
        frame_valid_s = frame_valid_r;
        frame_len_s   = frame_len_r;
        buf_we_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                err_s = 1'b0;
            end
            ST_LEN: begin
                if (timeout_s) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_TIMEOUT;
                end else if (bus.i_rx_dv && len_bad_s) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_LEN;
                end else begin
                    err_s = 1'b0;
                end
            end
            ST_PAYLOAD: begin
                if (timeout_s) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_TIMEOUT;
                end else if (bus.i_rx_dv) begin
                    buf_we_s = 1'b1;
                end else begin
                    buf_we_s = 1'b0;
                end
            end
            ST_CSUM: begin
                if (timeout_s) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_TIMEOUT;
                end else if (bus.i_rx_dv && (bus.i_rx_byte != sum_r)) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_CSUM;
                end else if (bus.i_rx_dv) begin
                    frame_valid_s = 1'b1;
                    frame_len_s   = len_r;
                end else begin
                    err_s = 1'b0;
                end
            end
            ST_DONE: begin
                overrun_s = bus.i_rx_dv;
                if (bus.i_frame_ack) frame_valid_s = 1'b0;
                else                 frame_valid_s = frame_valid_r;
            end
            default: begin
                frame_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: inter-byte timer, payload index, length and running sum
    always_comb begin
        timer_s = timer_r;
        idx_s   = idx_r;
        len_s   = len_r;
        sum_s   = sum_r;
        case (state_r)
            ST_IDLE: begin
                // Timer is held at zero so it starts cleared on entry to LEN
                timer_s = {TW{1'b0}};
                if (is_sync_s) begin
                    idx_s = {IW{1'b0}};
                    sum_s = 8'h00;
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_LEN: begin
                if (bus.i_rx_dv) begin
                    timer_s = {TW{1'b0}};
                    len_s   = bus.i_rx_byte;
                    idx_s   = {IW{1'b0}};
                    sum_s   = bus.i_rx_byte;
                end else begin
                    timer_s = timer_inc_s;
                end
            end
            ST_PAYLOAD: begin
                if (bus.i_rx_dv) begin
                    timer_s = {TW{1'b0}};
                    idx_s   = idx_r + IW'(1'b1);
                    sum_s   = sum8(sum_r, bus.i_rx_byte);
                end else begin
                    timer_s = timer_inc_s;
                end
            end
            ST_CSUM: begin
                if (bus.i_rx_dv) timer_s = {TW{1'b0}};
                else             timer_s = timer_inc_s;
            end
            ST_DONE: begin
                timer_s = {TW{1'b0}};
            end
            default: begin
                timer_s = {TW{1'b0}};
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= {TW{1'b0}};
            idx_r   <= {IW{1'b0}};
            len_r   <= 8'h00;
            sum_r   <= 8'h00;
        end else begin
            timer_r <= timer_s;
            idx_r   <= idx_s;
            len_r   <= len_s;
            sum_r   <= sum_s;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid_r <= 1'b0;
            frame_len_r   <= 8'h00;
            err_r         <= 1'b0;
            err_code_r    <= ERR_NONE;
            overrun_r     <= 1'b0;
        end else begin
            frame_valid_r <= frame_valid_s;
            frame_len_r   <= frame_len_s;
            err_r         <= err_s;
            err_code_r    <= err_code_s;
            overrun_r     <= overrun_s;
        end
    end

    uart_rx_frame_ctrl_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we_s),
        .waddr (idx_r[AW-1:0]),
        .wdata (bus.i_rx_byte),
        .raddr (bus.i_rd_addr),
        .rdata (rd_data_s)
    );

    assign bus.o_frame_valid = frame_valid_r;
    assign bus.o_frame_len   = frame_len_r;
    assign bus.o_err         = err_r;
    assign bus.o_err_code    = err_code_r;
    assign bus.o_overrun     = overrun_r;
    assign bus.o_rd_data     = rd_data_s;
endmodule
